// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package mc_pkg;

  // Controller states; one per datapath step of the multicycle sequence.
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  // Opcodes of the implemented instruction subset.
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALU operation class handed to the ALU decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // ALU operation codes seen by the ALU.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Result multiplexer select.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Immediate format select shared with the extend unit.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the ALU operation class and instruction fields to an ALU code.
module aludec
  import mc_pkg::*;
(
  input  aluop_t      alu_op,
  input  logic        op5,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [2:0]  alu_control
);

  // Pick the ALU operation; only R-type (op5=1) with funct7b5 turns add into sub.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: Moore FSM sequencing a shared-memory RV32I datapath,
// with a ready handshake on memory, a sticky illegal-opcode trap and a
// retired-instruction counter.
module mc_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             Trap,
  output logic [CNT_W-1:0] InstrCount
);

  state_t           state_q, state_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             retire;
  aluop_t           alu_op;

  // State, trap flag and counter registers; reset is asynchronous and active low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      trap_q        <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      trap_q        <= trap_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state selection; memory states hold until the access completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the last cycle of its sequence; a store only
  // retires once memory accepts the write.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BEQ: retire = 1'b1;
      S_MEMWRITE:              retire = MemReady;
      default:                 retire = 1'b0;
    endcase
    instr_count_d = retire ? (instr_count_q + CNT_W'(1)) : instr_count_q;
    trap_d        = trap_q | (state_d == S_TRAP);
  end

  // Moore output decode; FETCH write enables and BEQ PC write are gated by
  // the handshake and zero flag so PC and IR load exactly once.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WDATA;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_WDATA;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_WDATA;
        alu_op    = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = Zero;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
  end

  assign ImmSrc     = imm_src_of(op);
  assign Trap       = trap_q;
  assign InstrCount = instr_count_q;

  aludec u_aludec (
    .alu_op      (alu_op),
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Table-driven bench for mc_controller: each row is one clock cycle of
// inputs with hand-derived expected outputs and retired count.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        MemReady;
  logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic        Trap;
  logic [31:0] InstrCount;

  always #5 clk = ~clk;

  mc_controller #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .MemReq     (MemReq),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Trap       (Trap),
    .InstrCount (InstrCount)
  );

  // Bench-local state tags used only to pick the expected output pattern.
  localparam int ST_F  = 0;
  localparam int ST_D  = 1;
  localparam int ST_MA = 2;
  localparam int ST_MR = 3;
  localparam int ST_MW = 4;
  localparam int ST_WB = 5;
  localparam int ST_ER = 6;
  localparam int ST_EI = 7;
  localparam int ST_AW = 8;
  localparam int ST_BQ = 9;
  localparam int ST_JL = 10;
  localparam int ST_TR = 11;

  localparam logic [6:0] O_LW  = 7'b0000011;
  localparam logic [6:0] O_SW  = 7'b0100011;
  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_I   = 7'b0010011;
  localparam logic [6:0] O_BEQ = 7'b1100011;
  localparam logic [6:0] O_JAL = 7'b1101111;
  localparam logic [6:0] O_BAD = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        r;
    int          st;
    logic [1:0]  imm;
    logic [2:0]  ac;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  wire [17:0] out_vec = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                         ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Trap};

  // Expected packed outputs for a given state, written out from the control table.
  function automatic logic [17:0] expv(input int st, input logic r, input logic z,
                                       input logic [1:0] imm, input logic [2:0] ac);
    logic       mreq, mw, adr, irw, pcw, rw, trp;
    logic [1:0] rs, sa, sb;
    mreq = 0; mw = 0; adr = 0; irw = 0; pcw = 0; rw = 0; trp = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00;
    case (st)
      ST_F:  begin mreq = 1; irw = r; pcw = r; rs = 2'b10; sb = 2'b10; end
      ST_D:  begin sa = 2'b01; sb = 2'b01; end
      ST_MA: begin sa = 2'b10; sb = 2'b01; end
      ST_MR: begin mreq = 1; adr = 1; end
      ST_MW: begin mreq = 1; mw = 1; adr = 1; end
      ST_WB: begin rs = 2'b01; rw = 1; end
      ST_ER: begin sa = 2'b10; sb = 2'b00; end
      ST_EI: begin sa = 2'b10; sb = 2'b01; end
      ST_AW: begin rs = 2'b00; rw = 1; end
      ST_BQ: begin sa = 2'b10; sb = 2'b00; pcw = z; end
      ST_JL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      ST_TR: begin trp = 1; end
      default: ;
    endcase
    return {mreq, mw, adr, irw, pcw, rw, rs, sa, sb, imm, ac, trp};
  endfunction

  task automatic push(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input logic r, input int st,
                      input logic [1:0] imm, input logic [2:0] ac, input logic [31:0] cnt);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.r = r;
    v.st = st; v.imm = imm; v.ac = ac; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply every queued row one cycle at a time, compare, then empty the queue.
  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7;
      Zero = tbl[i].z; MemReady = tbl[i].r;
      #1;
      check($sformatf("%s_row%0d_outs", tag, i), {14'b0, out_vec},
            {14'b0, expv(tbl[i].st, tbl[i].r, tbl[i].z, tbl[i].imm, tbl[i].ac)});
      check($sformatf("%s_row%0d_count", tag, i), InstrCount, tbl[i].cnt);
      $display("%s row %0d op=%b st=%0d outs=%h cnt=%0d", tag, i, tbl[i].op,
               tbl[i].st, out_vec, InstrCount);
    end
    tbl.delete();
  endtask

  initial begin
    reset = 0; op = O_R; funct3 = 3'b000; funct7b5 = 0; Zero = 0; MemReady = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", {14'b0, out_vec}, {14'b0, expv(ST_F, 1'b0, 1'b0, 2'b00, 3'b000)});
    check("reset_count", InstrCount, 32'd0);
    check("reset_trap", {31'b0, Trap}, 32'd0);
    @(negedge clk);
    reset = 1;

    // add x3,x1,x2
    push(O_R, 3'b000, 0, 0, 1, ST_F,  2'b00, 3'b000, 0);
    push(O_R, 3'b000, 0, 0, 1, ST_D,  2'b00, 3'b000, 0);
    push(O_R, 3'b000, 0, 0, 1, ST_ER, 2'b00, 3'b000, 0);
    push(O_R, 3'b000, 0, 0, 1, ST_AW, 2'b00, 3'b000, 0);
    // sub
    push(O_R, 3'b000, 1, 0, 1, ST_F,  2'b00, 3'b000, 1);
    push(O_R, 3'b000, 1, 0, 1, ST_D,  2'b00, 3'b000, 1);
    push(O_R, 3'b000, 1, 0, 1, ST_ER, 2'b00, 3'b001, 1);
    push(O_R, 3'b000, 1, 0, 1, ST_AW, 2'b00, 3'b000, 1);
    // addi with imm bit 30 set: still add
    push(O_I, 3'b000, 1, 0, 1, ST_F,  2'b00, 3'b000, 2);
    push(O_I, 3'b000, 1, 0, 1, ST_D,  2'b00, 3'b000, 2);
    push(O_I, 3'b000, 1, 0, 1, ST_EI, 2'b00, 3'b000, 2);
    push(O_I, 3'b000, 1, 0, 1, ST_AW, 2'b00, 3'b000, 2);
    // slti
    push(O_I, 3'b010, 0, 0, 1, ST_F,  2'b00, 3'b000, 3);
    push(O_I, 3'b010, 0, 0, 1, ST_D,  2'b00, 3'b000, 3);
    push(O_I, 3'b010, 0, 0, 1, ST_EI, 2'b00, 3'b101, 3);
    push(O_I, 3'b010, 0, 0, 1, ST_AW, 2'b00, 3'b000, 3);
    // ori
    push(O_I, 3'b110, 0, 0, 1, ST_F,  2'b00, 3'b000, 4);
    push(O_I, 3'b110, 0, 0, 1, ST_D,  2'b00, 3'b000, 4);
    push(O_I, 3'b110, 0, 0, 1, ST_EI, 2'b00, 3'b011, 4);
    push(O_I, 3'b110, 0, 0, 1, ST_AW, 2'b00, 3'b000, 4);
    // andi
    push(O_I, 3'b111, 0, 0, 1, ST_F,  2'b00, 3'b000, 5);
    push(O_I, 3'b111, 0, 0, 1, ST_D,  2'b00, 3'b000, 5);
    push(O_I, 3'b111, 0, 0, 1, ST_EI, 2'b00, 3'b010, 5);
    push(O_I, 3'b111, 0, 0, 1, ST_AW, 2'b00, 3'b000, 5);
    // lw with two wait cycles in FETCH and in MEMREAD: 9 cycles
    push(O_LW, 3'b010, 0, 0, 0, ST_F,  2'b00, 3'b000, 6);
    push(O_LW, 3'b010, 0, 0, 0, ST_F,  2'b00, 3'b000, 6);
    push(O_LW, 3'b010, 0, 0, 1, ST_F,  2'b00, 3'b000, 6);
    push(O_LW, 3'b010, 0, 0, 1, ST_D,  2'b00, 3'b000, 6);
    push(O_LW, 3'b010, 0, 0, 1, ST_MA, 2'b00, 3'b000, 6);
    push(O_LW, 3'b010, 0, 0, 0, ST_MR, 2'b00, 3'b000, 6);
    push(O_LW, 3'b010, 0, 0, 0, ST_MR, 2'b00, 3'b000, 6);
    push(O_LW, 3'b010, 0, 0, 1, ST_MR, 2'b00, 3'b000, 6);
    push(O_LW, 3'b010, 0, 0, 1, ST_WB, 2'b00, 3'b000, 6);
    // beq taken
    push(O_BEQ, 3'b000, 0, 1, 1, ST_F,  2'b10, 3'b000, 7);
    push(O_BEQ, 3'b000, 0, 1, 1, ST_D,  2'b10, 3'b000, 7);
    push(O_BEQ, 3'b000, 0, 1, 1, ST_BQ, 2'b10, 3'b001, 7);
    // beq not taken
    push(O_BEQ, 3'b000, 0, 0, 1, ST_F,  2'b10, 3'b000, 8);
    push(O_BEQ, 3'b000, 0, 0, 1, ST_D,  2'b10, 3'b000, 8);
    push(O_BEQ, 3'b000, 0, 0, 1, ST_BQ, 2'b10, 3'b001, 8);
    // sw with three wait cycles in MEMWRITE
    push(O_SW, 3'b010, 0, 0, 1, ST_F,  2'b01, 3'b000, 9);
    push(O_SW, 3'b010, 0, 0, 1, ST_D,  2'b01, 3'b000, 9);
    push(O_SW, 3'b010, 0, 0, 1, ST_MA, 2'b01, 3'b000, 9);
    push(O_SW, 3'b010, 0, 0, 0, ST_MW, 2'b01, 3'b000, 9);
    push(O_SW, 3'b010, 0, 0, 0, ST_MW, 2'b01, 3'b000, 9);
    push(O_SW, 3'b010, 0, 0, 0, ST_MW, 2'b01, 3'b000, 9);
    push(O_SW, 3'b010, 0, 0, 1, ST_MW, 2'b01, 3'b000, 9);
    // jal
    push(O_JAL, 3'b000, 0, 0, 1, ST_F,  2'b11, 3'b000, 10);
    push(O_JAL, 3'b000, 0, 0, 1, ST_D,  2'b11, 3'b000, 10);
    push(O_JAL, 3'b000, 0, 0, 1, ST_JL, 2'b11, 3'b000, 10);
    push(O_JAL, 3'b000, 0, 0, 1, ST_AW, 2'b11, 3'b000, 10);
    // illegal opcode: trap then stay there
    push(O_BAD, 3'b000, 0, 0, 1, ST_F, 2'b00, 3'b000, 11);
    push(O_BAD, 3'b000, 0, 0, 1, ST_D, 2'b00, 3'b000, 11);
    for (int k = 0; k < 10; k++)
      push(O_BAD, 3'b000, 0, 1, 1, ST_TR, 2'b00, 3'b000, 11);
    run_table("main");

    // Asynchronous reset clears the trap with no clock edge in between.
    @(negedge clk);
    MemReady = 0;
    #1;
    check("trap_sticky", {31'b0, Trap}, 32'd1);
    #1 reset = 0;
    #1;
    check("async_trap_clear", {31'b0, Trap}, 32'd0);
    check("async_memreq", {31'b0, MemReq}, 32'd1);
    check("async_count_clear", InstrCount, 32'd0);
    check("async_outs", {14'b0, out_vec}, {14'b0, expv(ST_F, 1'b0, 1'b0, 2'b00, 3'b000)});
    $display("async reset trap=%0d memreq=%0d cnt=%0d", Trap, MemReq, InstrCount);
    @(negedge clk);
    reset = 1;

    // Counter wrap: preload all ones, retire one addi.
    @(negedge clk);
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    check("preload_count", InstrCount, 32'hFFFF_FFFF);
    push(O_I, 3'b000, 0, 0, 1, ST_F,  2'b00, 3'b000, 32'hFFFF_FFFF);
    push(O_I, 3'b000, 0, 0, 1, ST_D,  2'b00, 3'b000, 32'hFFFF_FFFF);
    push(O_I, 3'b000, 0, 0, 1, ST_EI, 2'b00, 3'b000, 32'hFFFF_FFFF);
    push(O_I, 3'b000, 0, 0, 1, ST_AW, 2'b00, 3'b000, 32'hFFFF_FFFF);
    push(O_I, 3'b000, 0, 0, 0, ST_F,  2'b00, 3'b000, 32'h0000_0000);
    push(O_I, 3'b000, 0, 0, 0, ST_F,  2'b00, 3'b000, 32'h0000_0000);
    run_table("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
